signed_divider16: RTL

//  Iterative signed divider, the inverse operator of the 8-bit signed multiplier. Divides a
//  16-bit signed dividend (e.g. accumulated MAC sum) by an 8-bit signed divisor (scale factor)
//  and yields a signed quotient and remainder. Sits after the neuron accumulators for

---
 rtl/sdiv_pkg.sv | 18 +
 rtl/sdiv_step.sv | 21 ++
 rtl/signed_divider16.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/sdiv_pkg.sv
// rtl/sdiv_pkg.sv - shared types and constants for the signed 16/8 divider
package sdiv_pkg;

    localparam int DIVIDEND_W_DEF = 16;
    localparam int DIVISOR_W_DEF  = 8;
    localparam int CNT_W          = $clog2(DIVIDEND_W_DEF + 1);

    localparam logic [DIVIDEND_W_DEF-1:0] Q_MAX = 16'h7FFF;
    localparam logic [DIVIDEND_W_DEF-1:0] Q_MIN = 16'h8000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/sdiv_step.sv
// rtl/sdiv_step.sv - one combinational restoring-division step on magnitudes
module sdiv_step #(
    parameter int DIVISOR_W = 8
) (
    input  logic [DIVISOR_W:0]   rem_i,
    input  logic                 bit_i,
    input  logic [DIVISOR_W-1:0] dvs_i,
    output logic [DIVISOR_W:0]   rem_o,
    output logic                 q_o
);

    logic [DIVISOR_W:0]   shifted;
    logic [DIVISOR_W+1:0] diff;

    assign shifted = {rem_i[DIVISOR_W-1:0], bit_i};
    assign diff    = {1'b0, shifted} - {2'b00, dvs_i};
    // A set bit shifted out of the top means the value already exceeds any divisor.
    assign q_o     = rem_i[DIVISOR_W] | ~diff[DIVISOR_W+1];
    assign rem_o   = q_o ? diff[DIVISOR_W:0] : shifted;

endmodule

// File: rtl/signed_divider16.sv
// rtl/signed_divider16.sv - iterative signed divider, 1 quotient bit per cycle
// Optional rounding of the quotient (half away from zero) under SDIV_ROUND_EN.
module signed_divider16
    import sdiv_pkg::*;
#(
    parameter int DIVIDEND_W = DIVIDEND_W_DEF,
    parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero,
    output logic                  overflow
);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
    logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
    logic [DIVISOR_W:0]    rem_q, rem_d;
    logic                  sdvd_q, sdvd_d;
    logic                  sdvs_q, sdvs_d;
    logic                  dz_q, dz_d;
    logic                  in_ready_q, in_ready_d;
    logic [DIVIDEND_W-1:0] quo_q, quo_d;
    logic [DIVISOR_W-1:0]  rout_q, rout_d;
    logic                  dzf_q, dzf_d;
    logic                  ovf_q, ovf_d;

    logic [DIVISOR_W:0]    step_rem;
    logic                  step_q;

    logic [DIVIDEND_W-1:0] qmag, fix_q;
    logic [DIVISOR_W-1:0]  rmag, fix_r;
    logic                  q_neg, fix_ov;

    sdiv_step #(.DIVISOR_W(DIVISOR_W)) u_step (
        .rem_i (rem_q),
        .bit_i (dvd_q[DIVIDEND_W-1]),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

    // After the last step dvd_q holds the quotient magnitude, rem_q the remainder magnitude.
    always_comb begin
        rmag  = rem_q[DIVISOR_W-1:0];
        qmag  = dvd_q;
`ifdef SDIV_ROUND_EN
        if ({rmag, 1'b0} >= {1'b0, dvs_q}) begin
            qmag = dvd_q + 1'b1;
        end
`endif
        q_neg  = sdvd_q ^ sdvs_q;
        fix_ov = !dz_q && !q_neg && qmag[DIVIDEND_W-1];
        fix_q  = q_neg ? -qmag : qmag;
        fix_r  = sdvd_q ? -rmag : rmag;
        if (dz_q) begin
            fix_q = sdvd_q ? Q_MIN : Q_MAX;
            fix_r = '0;
        end else if (fix_ov) begin
            fix_q = Q_MAX;
            fix_r = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        sdvd_d  = sdvd_q;
        sdvs_d  = sdvs_q;
        dz_d    = dz_q;
        quo_d   = quo_q;
        rout_d  = rout_q;
        dzf_d   = dzf_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    state_d = ST_DIV;
                    cnt_d   = CNT_W'(DIVIDEND_W);
                    dvd_d   = dividend[DIVIDEND_W-1] ? -dividend : dividend;
                    dvs_d   = divisor[DIVISOR_W-1] ? -divisor : divisor;
                    rem_d   = '0;
                    sdvd_d  = dividend[DIVIDEND_W-1];
                    sdvs_d  = divisor[DIVISOR_W-1];
                    dz_d    = (divisor == '0);
                end
            end
            ST_DIV: begin
                rem_d = step_rem;
                dvd_d = {dvd_q[DIVIDEND_W-2:0], step_q};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                quo_d   = fix_q;
                rout_d  = fix_r;
                dzf_d   = dz_q;
                ovf_d   = fix_ov;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        in_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            rem_q      <= '0;
            sdvd_q     <= 1'b0;
            sdvs_q     <= 1'b0;
            dz_q       <= 1'b0;
            in_ready_q <= 1'b0;
            quo_q      <= '0;
            rout_q     <= '0;
            dzf_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
            rem_q      <= rem_d;
            sdvd_q     <= sdvd_d;
            sdvs_q     <= sdvs_d;
            dz_q       <= dz_d;
            in_ready_q <= in_ready_d;
            quo_q      <= quo_d;
            rout_q     <= rout_d;
            dzf_q      <= dzf_d;
            ovf_q      <= ovf_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = (state_q == ST_DONE);
    assign quotient    = quo_q;
    assign remainder   = rout_q;
    assign div_by_zero = dzf_q;
    assign overflow    = ovf_q;

endmodule
